// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: m0 has priority, m1 is guaranteed a
// slot after BURST_MAX back-to-back m0 grants. Fixed-latency access sequence.
module mem_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int BURST_MAX   = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_byte_half,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_byte_half,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,

  output logic [15:0] mem_addr,
  output logic [15:0] mem_in,
  output logic        mem_we,
  output logic        mem_byte_half,
  input  logic [15:0] mem_out,

  output logic        busy,
  output logic        owner
);

  // state    | meaning
  // S_IDLE   | no transaction; arbitrate and latch winner on any request
  // S_ACCESS | memory driven from latched fields; wait counter runs down
  // S_ACK    | one-cycle ack to owner; requests ignored

  localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int CCW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(WAIT_STATES);
  localparam logic [CCW-1:0] CONSEC_MAX = CCW'(BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [CCW-1:0] consec_q, consec_d;
  logic           owner_q, owner_d;
  logic           we_q, we_d;
  logic           busy_q, busy_d;
  logic           mem_we_q, mem_we_d;
  logic           mem_byte_half_q, mem_byte_half_d;
  logic [15:0]    mem_addr_q, mem_addr_d;
  logic [15:0]    mem_in_q, mem_in_d;
  logic           m0_ack_q, m0_ack_d;
  logic           m1_ack_q, m1_ack_d;
  logic [15:0]    m0_rdata_q, m0_rdata_d;
  logic [15:0]    m1_rdata_q, m1_rdata_d;
  logic           grant_m1;
  logic           grant_we;

  // m1 wins when alone, or when m0 has used up its burst allowance
  assign grant_m1 = m1_req & (~m0_req | (consec_q == CONSEC_MAX));
  assign grant_we = grant_m1 ? m1_we : m0_we;

  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    consec_d        = consec_q;
    owner_d         = owner_q;
    we_d            = we_q;
    busy_d          = busy_q;
    mem_we_d        = mem_we_q;
    mem_byte_half_d = mem_byte_half_q;
    mem_addr_d      = mem_addr_q;
    mem_in_d        = mem_in_q;
    m0_ack_d        = 1'b0;
    m1_ack_d        = 1'b0;
    m0_rdata_d      = m0_rdata_q;
    m1_rdata_d      = m1_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          owner_d         = grant_m1;
          we_d            = grant_we;
          mem_we_d        = grant_we;
          mem_byte_half_d = grant_m1 ? m1_byte_half : m0_byte_half;
          mem_addr_d      = grant_m1 ? m1_addr : m0_addr;
          mem_in_d        = grant_m1 ? m1_wdata : m0_wdata;
          wait_d          = WAIT_LOAD;
          busy_d          = 1'b1;
          state_d         = S_ACCESS;
          if (grant_m1 || !m1_req) begin
            consec_d = '0;
          end else if (consec_q != CONSEC_MAX) begin
            consec_d = consec_q + 1'b1;
          end
        end
      end

      S_ACCESS: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          if (!we_q) begin
            if (owner_q) m1_rdata_d = mem_out;
            else         m0_rdata_d = mem_out;
          end
          mem_we_d = 1'b0;
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = S_ACK;
        end
      end

      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d   = 1'b0;
        mem_we_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wait_q          <= '0;
      consec_q        <= '0;
      owner_q         <= 1'b0;
      we_q            <= 1'b0;
      busy_q          <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_byte_half_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_in_q        <= '0;
      m0_ack_q        <= 1'b0;
      m1_ack_q        <= 1'b0;
      m0_rdata_q      <= '0;
      m1_rdata_q      <= '0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      consec_q        <= consec_d;
      owner_q         <= owner_d;
      we_q            <= we_d;
      busy_q          <= busy_d;
      mem_we_q        <= mem_we_d;
      mem_byte_half_q <= mem_byte_half_d;
      mem_addr_q      <= mem_addr_d;
      mem_in_q        <= mem_in_d;
      m0_ack_q        <= m0_ack_d;
      m1_ack_q        <= m1_ack_d;
      m0_rdata_q      <= m0_rdata_d;
      m1_rdata_q      <= m1_rdata_d;
    end
  end

  assign m0_ack        = m0_ack_q;
  assign m1_ack        = m1_ack_q;
  assign m0_rdata      = m0_rdata_q;
  assign m1_rdata      = m1_rdata_q;
  assign mem_addr      = mem_addr_q;
  assign mem_in        = mem_in_q;
  assign mem_we        = mem_we_q;
  assign mem_byte_half = mem_byte_half_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_STATES 0 and 2) share one stimulus
// stream; a transaction-timeline model is compared every cycle plus literal checks.
module tb_mem_arbiter;

  localparam int WS0 = 0;
  localparam int WS1 = 2;
  localparam int BM  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_bh = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_bh = 1'b0;
  logic [15:0] m1_addr = '0, m1_wdata = '0;

  logic        m0_ack [2];
  logic        m1_ack [2];
  logic [15:0] m0_rdata [2];
  logic [15:0] m1_rdata [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_in [2];
  logic [15:0] mem_out [2];
  logic        mem_we [2];
  logic        mem_bh [2];
  logic        busy [2];
  logic        owner [2];

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_pat(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic int ws(input int i);
    return (i == 0) ? WS0 : WS1;
  endfunction

  assign mem_out[0] = rd_pat(mem_addr[0]);
  assign mem_out[1] = rd_pat(mem_addr[1]);

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.WAIT_STATES((g == 0) ? WS0 : WS1), .BURST_MAX(BM)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_req       (m0_req),
      .m0_we        (m0_we),
      .m0_byte_half (m0_bh),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_ack       (m0_ack[g]),
      .m0_rdata     (m0_rdata[g]),
      .m1_req       (m1_req),
      .m1_we        (m1_we),
      .m1_byte_half (m1_bh),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_ack       (m1_ack[g]),
      .m1_rdata     (m1_rdata[g]),
      .mem_addr     (mem_addr[g]),
      .mem_in       (mem_in[g]),
      .mem_we       (mem_we[g]),
      .mem_byte_half(mem_bh[g]),
      .mem_out      (mem_out[g]),
      .busy         (busy[g]),
      .owner        (owner[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline of elapsed cycles since its grant.
  logic        md_act [2];
  int          md_e [2];
  logic        md_own [2];
  logic        md_we [2];
  logic        md_bh [2];
  logic [15:0] md_addr [2];
  logic [15:0] md_wd [2];
  logic [15:0] md_rd0 [2];
  logic [15:0] md_rd1 [2];
  int          md_consec [2];
  logic        md_w;

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        md_act[i] = 1'b0; md_e[i] = 0; md_own[i] = 1'b0; md_we[i] = 1'b0;
        md_bh[i] = 1'b0; md_addr[i] = '0; md_wd[i] = '0;
        md_rd0[i] = '0; md_rd1[i] = '0; md_consec[i] = 0;
      end else if (md_act[i]) begin
        md_e[i] = md_e[i] + 1;
        if (md_e[i] == ws(i) + 2 && !md_we[i]) begin
          if (md_own[i]) md_rd1[i] = rd_pat(md_addr[i]);
          else           md_rd0[i] = rd_pat(md_addr[i]);
        end
        if (md_e[i] == ws(i) + 3) md_act[i] = 1'b0;
      end else if (m0_req || m1_req) begin
        md_w = m1_req && (!m0_req || md_consec[i] == BM);
        if (md_w || !m1_req) md_consec[i] = 0;
        else if (md_consec[i] < BM) md_consec[i] = md_consec[i] + 1;
        md_own[i]  = md_w;
        md_we[i]   = md_w ? m1_we : m0_we;
        md_bh[i]   = md_w ? m1_bh : m0_bh;
        md_addr[i] = md_w ? m1_addr : m0_addr;
        md_wd[i]   = md_w ? m1_wdata : m0_wdata;
        md_act[i]  = 1'b1;
        md_e[i]    = 1;
      end
    end
  end

  logic e_acc, e_ack;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        e_acc = md_act[i] && (md_e[i] <= ws(i) + 1);
        e_ack = md_act[i] && (md_e[i] == ws(i) + 2);
        chk($sformatf("cyc_mem_we[%0d]", i), 32'(mem_we[i]), 32'(e_acc && md_we[i]));
        chk($sformatf("cyc_mem_addr[%0d]", i), 32'(mem_addr[i]), 32'(md_addr[i]));
        chk($sformatf("cyc_mem_in[%0d]", i), 32'(mem_in[i]), 32'(md_wd[i]));
        chk($sformatf("cyc_mem_bh[%0d]", i), 32'(mem_bh[i]), 32'(md_bh[i]));
        chk($sformatf("cyc_m0_ack[%0d]", i), 32'(m0_ack[i]), 32'(e_ack && !md_own[i]));
        chk($sformatf("cyc_m1_ack[%0d]", i), 32'(m1_ack[i]), 32'(e_ack && md_own[i]));
        chk($sformatf("cyc_m0_rdata[%0d]", i), 32'(m0_rdata[i]), 32'(md_rd0[i]));
        chk($sformatf("cyc_m1_rdata[%0d]", i), 32'(m1_rdata[i]), 32'(md_rd1[i]));
        chk($sformatf("cyc_busy[%0d]", i), 32'(busy[i]), 32'(md_act[i]));
        chk($sformatf("cyc_owner[%0d]", i), 32'(owner[i]), 32'(md_own[i]));
      end
    end
  end

  task automatic set_m0(input logic r, input logic w, input logic b,
                        input logic [15:0] a, input logic [15:0] d);
    m0_req = r; m0_we = w; m0_bh = b; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic b,
                        input logic [15:0] a, input logic [15:0] d);
    m1_req = r; m1_we = w; m1_bh = b; m1_addr = a; m1_wdata = d;
  endtask

  int a0 [2];
  int a1 [2];
  int n0 [2];
  int n1 [2];
  int wec [2];
  int bad [2];
  logic [9:0] ord_bits [2];
  int ord_n [2];

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin
      a0[i] = 0; a1[i] = 0; n0[i] = 0; n1[i] = 0; wec[i] = 0; bad[i] = 0;
    end
  endtask

  // Observe one negedge: index n of first ack, ack counts, write cycles.
  task automatic observe(input int n, input logic [15:0] wa, input logic [15:0] wd);
    for (int i = 0; i < 2; i++) begin
      if (m0_ack[i]) begin n0[i]++; if (a0[i] == 0) a0[i] = n; end
      if (m1_ack[i]) begin n1[i]++; if (a1[i] == 0) a1[i] = n; end
      if (mem_we[i]) begin
        wec[i]++;
        if (mem_addr[i] != wa || mem_in[i] != wd) bad[i]++;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr[1]), 32'd0);
    chk("rst_m0_rdata", 32'(m0_rdata[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // m0 read of 0x0010
    clr_stats();
    set_m0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        m0_req = 1'b0;
        chk("t1_access_addr", 32'(mem_addr[0]), 32'h0010);
      end
      observe(n, 16'hFFFF, 16'hFFFF);
    end
    chk("t1_ack_at_ws0", 32'(a0[0]), 32'd2);
    chk("t1_ack_at_ws2", 32'(a0[1]), 32'd4);
    chk("t1_no_m1_ack", 32'(n1[0] + n1[1]), 32'd0);
    chk("t1_no_write", 32'(wec[0] + wec[1]), 32'd0);
    chk("t1_rdata_ws0", 32'(m0_rdata[0]), 32'hBEEF);
    chk("t1_rdata_ws2", 32'(m0_rdata[1]), 32'hBEEF);

    // m1 write 0x1234 to 0x0100
    clr_stats();
    set_m1(1'b1, 1'b1, 1'b1, 16'h0100, 16'h1234);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) m1_req = 1'b0;
      observe(n, 16'h0100, 16'h1234);
    end
    chk("t2_we_cycles_ws2", 32'(wec[1]), 32'd3);
    chk("t2_we_cycles_ws0", 32'(wec[0]), 32'd1);
    chk("t2_we_fields", 32'(bad[0] + bad[1]), 32'd0);
    chk("t2_ack_at_ws2", 32'(a1[1]), 32'd4);
    chk("t2_ack_at_ws0", 32'(a1[0]), 32'd2);
    chk("t2_no_m0_ack", 32'(n0[0] + n0[1]), 32'd0);
    chk("t2_m0_rdata_kept", 32'(m0_rdata[1]), 32'hBEEF);
    chk("t2_m1_rdata_kept", 32'(m1_rdata[1]), 32'h0000);
    m1_we = 1'b0;
    repeat (2) @(negedge clk);

    // both held: burst limit gives m1 every fifth grant
    for (int i = 0; i < 2; i++) begin ord_bits[i] = '0; ord_n[i] = 0; end
    set_m0(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000);
    set_m1(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000);
    for (int k = 0; k < 100 && (ord_n[0] < 10 || ord_n[1] < 10); k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ord_n[i] < 10 && (m0_ack[i] || m1_ack[i])) begin
          ord_bits[i] = {ord_bits[i][8:0], m1_ack[i]};
          ord_n[i]++;
        end
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("t3_count_ws0", 32'(ord_n[0]), 32'd10);
    chk("t3_count_ws2", 32'(ord_n[1]), 32'd10);
    chk("t3_order_ws0", 32'(ord_bits[0]), 32'b0000100001);
    chk("t3_order_ws2", 32'(ord_bits[1]), 32'b0000100001);
    repeat (12) @(negedge clk);
    chk("t3_m0_rdata", 32'(m0_rdata[1]), 32'h585A);
    chk("t3_m1_rdata", 32'(m1_rdata[1]), 32'h595A);

    // inputs change and req drops after grant
    clr_stats();
    set_m0(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin m0_addr = 16'h0FFF; m0_we = 1'b1; m0_req = 1'b0; end
      if (n == 3) begin
        chk("t4_addr_hold_ws0", 32'(mem_addr[0]), 32'h0020);
        chk("t4_addr_hold_ws2", 32'(mem_addr[1]), 32'h0020);
      end
      observe(n, 16'hFFFF, 16'hFFFF);
    end
    m0_we = 1'b0;
    chk("t4_one_ack_ws0", 32'(n0[0]), 32'd1);
    chk("t4_one_ack_ws2", 32'(n0[1]), 32'd1);
    chk("t4_rdata", 32'(m0_rdata[1]), 32'h5A7A);
    chk("t4_no_write", 32'(wec[0] + wec[1]), 32'd0);

    // reset during the m1 write access
    clr_stats();
    set_m1(1'b1, 1'b1, 1'b0, 16'h0400, 16'hCAFE);
    @(negedge clk);
    m1_req = 1'b0;
    @(negedge clk);
    chk("t5_we_before_rst", 32'(mem_we[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_we_in_rst", 32'(mem_we[1]), 32'd0);
    chk("t5_busy_in_rst", 32'(busy[1]), 32'd0);
    chk("t5_ack_in_rst", 32'(m1_ack[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      observe(n, 16'h0400, 16'hCAFE);
    end
    chk("t5_no_m1_ack", 32'(n1[0] + n1[1]), 32'd0);
    chk("t5_m1_rdata_cleared", 32'(m1_rdata[1]), 32'h0000);
    clr_stats();
    m1_we = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) m0_req = 1'b0;
      observe(n, 16'hFFFF, 16'hFFFF);
    end
    chk("t5_fresh_ack_ws2", 32'(a0[1]), 32'd4);
    chk("t5_fresh_ack_ws0", 32'(a0[0]), 32'd2);
    chk("t5_fresh_rdata", 32'(m0_rdata[1]), 32'hBEEF);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
